proc_debug_ctrl: RTL and testbench
==================================

Name: proc_debug_ctrl

Overview:
- Run-control and trace block placed between the board/host and the 16-bit multi-cycle processor.
- Drives the processor's Run input and watches its Done pulse and PC.
- Provides free-run, N-instruction step, halt-on-command, PC breakpoints, instruction/cycle counters and a PC trace FIFO.
- Replaces hand-clocked instruction stepping, and is parametrised in data width, breakpoint count and trace depth.

Parameters:
DATA_W, 16, processor data/PC width
NUM_BP, 2, number of PC breakpoint comparators (1..8)
TRACE_DEPTH, 8, trace FIFO entries (power of two, >=2)
CNT_W, 32, width of instruction and cycle counters
STEP_W, 8, width of step-count argument

Ports:
Clock  in  1  single clock, rising edge
Reset  in  1  asynchronous, active-high; clears all state
cmd_valid  in  1  command strobe
cmd_op  in  3  0 NOP, 1 RUN, 2 STEP, 3 HALT, 4 CLR
cmd_arg  in  STEP_W  step count for STEP
cmd_ready  out  1  command accepted when cmd_valid&cmd_ready
bp_wr  in  1  write breakpoint slot
bp_idx  in  clog2(NUM_BP)  slot index
bp_addr  in  DATA_W  breakpoint PC
bp_en  in  1  slot enable
proc_run  out  1  processor Run
proc_done  in  1  processor Done, one-cycle pulse per completed instruction
proc_pc  in  DATA_W  processor PC (address of next instruction when Done=1)
halted  out  1  controller in HALT
halt_cause  out  2  0 none, 1 command, 2 step complete, 3 breakpoint
instr_count  out  CNT_W  completed instructions
cycle_count  out  CNT_W  cycles with proc_run=1
trace_rd  in  1  pop trace FIFO
trace_pc  out  DATA_W  oldest trace entry (valid when !trace_empty)
trace_empty  out  1  FIFO empty
trace_count  out  clog2(TRACE_DEPTH)+1  occupancy
trace_overflow  out  1  sticky: an entry was overwritten

Behaviour:
- Reset values:
  - state HALT, halted=1, halt_cause=0, proc_run=0.
  - Counters 0; FIFO empty; overflow=0.
  - All breakpoints disabled, addr 0.
- States: HALT, RUN, STEP, DRAIN. The processor starts an instruction only while Run=1; stopping therefore happens only on a Done boundary.
- proc_run = run_q & ~(proc_done & stop_now). run_q is the registered "state is RUN/STEP/DRAIN". The gating means no new instruction begins in the cycle Done triggers a stop.
- stop_now, evaluated only on proc_done:
  - breakpoint hit: any enabled slot with bp_addr==proc_pc;
  - STEP with remaining==1;
  - state DRAIN.
- cmd_ready = 1 in HALT and RUN; 0 in STEP and DRAIN.
- Commands by state:
  - HALT:
    - RUN -> RUN.
    - STEP with arg>0 -> STEP, remaining=arg; arg=0 is a no-op.
    - CLR clears counters, FIFO, overflow and halt_cause.
    - HALT/NOP ignored.
  - RUN:
    - HALT -> DRAIN.
    - Others ignored.
- Transitions:
  - RUN -> HALT on breakpoint (cause 3).
  - DRAIN -> HALT on next Done (cause 1). If Done coincides with an accepted HALT command, go straight to HALT with cause 1, unless a breakpoint also hit (cause 3).
  - STEP: remaining decrements on each Done. Reaching 0 -> HALT cause 2. A breakpoint hit in the same Done has priority (cause 3).
- Resume from a breakpoint is guaranteed to execute at least one instruction, because matches are checked only on Done.
- Breakpoint writes are allowed in any state and take effect the next cycle.
- Counters: instr_count +1 per proc_done; cycle_count +1 per cycle with proc_run=1. Both saturate at all-ones, no wrap.
- Trace:
  - Every proc_done pushes proc_pc.
  - Push while full overwrites the oldest entry and sets trace_overflow.
  - Push and pop in the same cycle when full: pop the oldest, push the new entry, count unchanged, no overflow.
  - Pop while empty is ignored.
  - trace_pc is a registered read of the head entry.
- Reset asserted mid-instruction drops Run immediately (asynchronous) and loses all state. The processor is reset by the same signal at board level.

Decomposition:
- Package proc_dbg_pkg: cmd_op encodings, halt_cause encodings, state enum.
- One sub-module: proc_trace_fifo (circular buffer with overwrite-on-full, DEPTH and WIDTH params).
- Breakpoint compare is a generate loop in the top module.

Test Plan:
- Reset, then STEP arg=3 with Done every 4 cycles -> exactly 3 Done pulses, halted=1, halt_cause=2, instr_count=3, trace holds the 3 PCs in order, proc_run=0 in the Done cycle of instruction 3.
- bp slot0=0x0004 enabled, RUN, PC sequence 1,2,3,4 -> halt on Done with pc=0x0004, cause 3. A second RUN executes at least one more instruction.
- RUN, then HALT issued mid-instruction -> cmd_ready drops, Run stays 1 until the next Done, then halted, cause 1, no further Done.
- 10 Done pulses with TRACE_DEPTH=8 and no reads -> trace_count=8, overflow=1, first pop returns the 3rd PC. Then CLR in HALT -> empty, overflow=0, counters 0.
- STEP arg=2 with bp matching the 2nd Done's PC -> cause 3, not 2. STEP arg=0 -> stays HALT, no Run.
- Reset asserted while in RUN -> proc_run=0 asynchronously, counters 0, halted=1 without waiting for a clock edge.

Source files
------------

// File: rtl/proc_dbg_pkg.sv
// Shared encodings for the processor debug controller: command opcodes,
// halt causes and the run-control state machine states.
package proc_dbg_pkg;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_RUN  = 3'd1,
        OP_STEP = 3'd2,
        OP_HALT = 3'd3,
        OP_CLR  = 3'd4
    } cmd_op_e;

    typedef enum logic [1:0] {
        CAUSE_NONE = 2'd0,
        CAUSE_CMD  = 2'd1,
        CAUSE_STEP = 2'd2,
        CAUSE_BP   = 2'd3
    } halt_cause_e;

    typedef enum logic [1:0] {
        ST_HALT  = 2'd0,
        ST_RUN   = 2'd1,
        ST_STEP  = 2'd2,
        ST_DRAIN = 2'd3
    } state_e;

endpackage

// File: rtl/proc_trace_fifo.sv
// Circular PC trace buffer: a push while full drops the oldest entry and
// raises a sticky overflow flag; the head entry is presented registered.
module proc_trace_fifo
    import proc_dbg_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int WIDTH = 16
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             overflow_q, overflow_d;
    logic [WIDTH-1:0] rd_data_q, rd_data_d;
    logic             full;
    logic             pop_eff;
    logic             shift_on_push;

    always_comb begin
        full          = (count_q == (PTR_W + 1)'(DEPTH));
        pop_eff       = pop && (count_q != '0);
        shift_on_push = push && full;

        wr_ptr_d   = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d   = (pop_eff || shift_on_push) ? rd_ptr_q + 1'b1 : rd_ptr_q;
        overflow_d = overflow_q || (push && full && !pop_eff);

        count_d = count_q;
        if (push && !full && !pop_eff) begin
            count_d = count_q + 1'b1;
        end else if (pop_eff && !push) begin
            count_d = count_q - 1'b1;
        end

        // A push landing on the new head slot must be forwarded, the array is not yet written
        rd_data_d = (push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem_q[rd_ptr_d];

        if (clr) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
            rd_data_d  = '0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
            rd_data_q  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
            rd_data_q  <= rd_data_d;
            if (push && !clr) begin
                mem_q[wr_ptr_q] <= push_data;
            end
        end
    end

    assign rd_data  = rd_data_q;
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign overflow = overflow_q;

endmodule

// File: rtl/proc_debug_ctrl.sv
// Run-control and trace front end for the multi-cycle processor: free run,
// N-step, command halt, PC breakpoints, counters and a PC trace FIFO.
module proc_debug_ctrl
    import proc_dbg_pkg::*;
#(
    parameter int DATA_W      = 16,
    parameter int NUM_BP      = 2,
    parameter int TRACE_DEPTH = 8,
    parameter int CNT_W       = 32,
    parameter int STEP_W      = 8
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   cmd_valid,
    input  logic [2:0]                             cmd_op,
    input  logic [STEP_W-1:0]                      cmd_arg,
    output logic                                   cmd_ready,
    input  logic                                   bp_wr,
    input  logic [((NUM_BP > 1) ? $clog2(NUM_BP) : 1)-1:0] bp_idx,
    input  logic [DATA_W-1:0]                      bp_addr,
    input  logic                                   bp_en,
    output logic                                   proc_run,
    input  logic                                   proc_done,
    input  logic [DATA_W-1:0]                      proc_pc,
    output logic                                   halted,
    output logic [1:0]                             halt_cause,
    output logic [CNT_W-1:0]                       instr_count,
    output logic [CNT_W-1:0]                       cycle_count,
    input  logic                                   trace_rd,
    output logic [DATA_W-1:0]                      trace_pc,
    output logic                                   trace_empty,
    output logic [$clog2(TRACE_DEPTH):0]           trace_count,
    output logic                                   trace_overflow
);

    localparam int BP_IDX_W = (NUM_BP > 1) ? $clog2(NUM_BP) : 1;

    state_e            state_q, state_d;
    logic              run_q, run_d;
    logic [STEP_W-1:0] remaining_q, remaining_d;
    halt_cause_e       cause_q, cause_d;
    logic [CNT_W-1:0]  instr_q, instr_d;
    logic [CNT_W-1:0]  cycle_q, cycle_d;
    logic [NUM_BP-1:0] bp_match;
    logic              bp_hit;
    logic              cmd_fire;
    logic              halt_accept;
    logic              stop_now;
    logic              clr_cmd;

    for (genvar i = 0; i < NUM_BP; i++) begin : g_bp
        logic [DATA_W-1:0] addr_q, addr_d;
        logic              en_q, en_d;

        always_comb begin
            addr_d = addr_q;
            en_d   = en_q;
            if (bp_wr && (bp_idx == BP_IDX_W'(i))) begin
                addr_d = bp_addr;
                en_d   = bp_en;
            end
        end

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                addr_q <= '0;
                en_q   <= 1'b0;
            end else begin
                addr_q <= addr_d;
                en_q   <= en_d;
            end
        end

        assign bp_match[i] = en_q && (addr_q == proc_pc);
    end

    assign bp_hit      = |bp_match;
    assign cmd_fire    = cmd_valid && ((state_q == ST_HALT) || (state_q == ST_RUN));
    assign halt_accept = cmd_fire && (state_q == ST_RUN) && (cmd_op == OP_HALT);

    // Stop decision only matters on a Done boundary; it gates Run so no new instruction starts
    assign stop_now = bp_hit
                   || ((state_q == ST_STEP) && (remaining_q == STEP_W'(1)))
                   || (state_q == ST_DRAIN)
                   || halt_accept;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HALT;
            run_q       <= 1'b0;
            remaining_q <= '0;
            cause_q     <= CAUSE_NONE;
            instr_q     <= '0;
            cycle_q     <= '0;
        end else begin
            state_q     <= state_d;
            run_q       <= run_d;
            remaining_q <= remaining_d;
            cause_q     <= cause_d;
            instr_q     <= instr_d;
            cycle_q     <= cycle_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        remaining_d = remaining_q;
        cause_d     = cause_q;
        clr_cmd     = 1'b0;
        unique case (state_q)
            ST_HALT: begin
                if (cmd_fire) begin
                    if (cmd_op == OP_RUN) begin
                        state_d = ST_RUN;
                    end else if ((cmd_op == OP_STEP) && (cmd_arg != '0)) begin
                        state_d     = ST_STEP;
                        remaining_d = cmd_arg;
                    end else if (cmd_op == OP_CLR) begin
                        clr_cmd = 1'b1;
                        cause_d = CAUSE_NONE;
                    end
                end
            end
            ST_RUN: begin
                if (proc_done && bp_hit) begin
                    state_d = ST_HALT;
                    cause_d = CAUSE_BP;
                end else if (halt_accept) begin
                    state_d = proc_done ? ST_HALT : ST_DRAIN;
                    if (proc_done) begin
                        cause_d = CAUSE_CMD;
                    end
                end
            end
            ST_STEP: begin
                if (proc_done) begin
                    remaining_d = remaining_q - 1'b1;
                    if (bp_hit) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_BP;
                    end else if (remaining_q == STEP_W'(1)) begin
                        state_d = ST_HALT;
                        cause_d = CAUSE_STEP;
                    end
                end
            end
            ST_DRAIN: begin
                if (proc_done) begin
                    state_d = ST_HALT;
                    cause_d = bp_hit ? CAUSE_BP : CAUSE_CMD;
                end
            end
            default: state_d = ST_HALT;
        endcase
        run_d = (state_d != ST_HALT);
    end

    always_comb begin
        cmd_ready = (state_q == ST_HALT) || (state_q == ST_RUN);
        halted    = (state_q == ST_HALT);
        proc_run  = run_q && !(proc_done && stop_now);
    end

    // Counters saturate rather than wrap so a long run never reads as a short one
    always_comb begin
        instr_d = instr_q;
        cycle_d = cycle_q;
        if (clr_cmd) begin
            instr_d = '0;
            cycle_d = '0;
        end else begin
            if (proc_done && (instr_q != '1)) begin
                instr_d = instr_q + 1'b1;
            end
            if (proc_run && (cycle_q != '1)) begin
                cycle_d = cycle_q + 1'b1;
            end
        end
    end

    proc_trace_fifo #(
        .DEPTH (TRACE_DEPTH),
        .WIDTH (DATA_W)
    ) u_trace (
        .clk       (clk),
        .rst       (rst),
        .clr       (clr_cmd),
        .push      (proc_done),
        .push_data (proc_pc),
        .pop       (trace_rd),
        .rd_data   (trace_pc),
        .empty     (trace_empty),
        .count     (trace_count),
        .overflow  (trace_overflow)
    );

    assign halt_cause  = cause_q;
    assign instr_count = instr_q;
    assign cycle_count = cycle_q;

endmodule

// File: tb/tb_proc_debug_ctrl.sv
// Directed bench for proc_debug_ctrl: stepping, breakpoints, command halt,
// trace wrap and asynchronous reset, each checked against hand-derived values.
module tb_proc_debug_ctrl;
    import proc_dbg_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cmd_valid = 1'b0;
    logic [2:0]  cmd_op = 3'd0;
    logic [7:0]  cmd_arg = 8'd0;
    logic        cmd_ready;
    logic        bp_wr = 1'b0;
    logic [0:0]  bp_idx = 1'b0;
    logic [15:0] bp_addr = 16'd0;
    logic        bp_en = 1'b0;
    logic        proc_run;
    logic        proc_done = 1'b0;
    logic [15:0] proc_pc = 16'd0;
    logic        halted;
    logic [1:0]  halt_cause;
    logic [31:0] instr_count;
    logic [31:0] cycle_count;
    logic        trace_rd = 1'b0;
    logic [15:0] trace_pc;
    logic        trace_empty;
    logic [3:0]  trace_count;
    logic        trace_overflow;

    int total = 0;
    int bad   = 0;

    proc_debug_ctrl #(
        .DATA_W      (16),
        .NUM_BP      (2),
        .TRACE_DEPTH (8),
        .CNT_W       (32),
        .STEP_W      (8)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .cmd_valid      (cmd_valid),
        .cmd_op         (cmd_op),
        .cmd_arg        (cmd_arg),
        .cmd_ready      (cmd_ready),
        .bp_wr          (bp_wr),
        .bp_idx         (bp_idx),
        .bp_addr        (bp_addr),
        .bp_en          (bp_en),
        .proc_run       (proc_run),
        .proc_done      (proc_done),
        .proc_pc        (proc_pc),
        .halted         (halted),
        .halt_cause     (halt_cause),
        .instr_count    (instr_count),
        .cycle_count    (cycle_count),
        .trace_rd       (trace_rd),
        .trace_pc       (trace_pc),
        .trace_empty    (trace_empty),
        .trace_count    (trace_count),
        .trace_overflow (trace_overflow)
    );

    always #5 clk = ~clk;

    // All stimulus tasks start and end on a falling edge
    task automatic send_cmd(input logic [2:0] op, input logic [7:0] arg);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_arg   = arg;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_op    = 3'd0;
        cmd_arg   = 8'd0;
    endtask

    task automatic write_bp(input logic idx, input logic [15:0] addr, input logic en);
        bp_wr   = 1'b1;
        bp_idx  = idx;
        bp_addr = addr;
        bp_en   = en;
        @(negedge clk);
        bp_wr   = 1'b0;
    endtask

    task automatic pulse_done(input logic [15:0] pc, input int gap, input logic pop,
                              output logic run_seen);
        repeat (gap) @(negedge clk);
        proc_done = 1'b1;
        proc_pc   = pc;
        trace_rd  = pop;
        #1;
        run_seen  = proc_run;
        @(negedge clk);
        proc_done = 1'b0;
        trace_rd  = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL reset_halted got=%0b want=1", halted); end
        total++; if (halt_cause !== 2'd0) begin bad++; $display("FAIL reset_cause got=%0d want=0", halt_cause); end
        total++; if (proc_run !== 1'b0) begin bad++; $display("FAIL reset_run got=%0b want=0", proc_run); end
        total++; if (instr_count !== 32'd0) begin bad++; $display("FAIL reset_instr got=%0d want=0", instr_count); end
        total++; if (cycle_count !== 32'd0) begin bad++; $display("FAIL reset_cycle got=%0d want=0", cycle_count); end
        total++; if (trace_empty !== 1'b1 || trace_count !== 4'd0) begin bad++; $display("FAIL reset_trace empty=%0b count=%0d want 1/0", trace_empty, trace_count); end
        total++; if (trace_overflow !== 1'b0) begin bad++; $display("FAIL reset_ovf got=%0b want=0", trace_overflow); end
        rst = 1'b0;
        @(negedge clk);
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", cmd_ready); end
    endtask

    task automatic test_step();
        logic rs;
        send_cmd(OP_STEP, 8'd3);
        total++; if (proc_run !== 1'b1) begin bad++; $display("FAIL step_run got=%0b want=1", proc_run); end
        total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL step_ready got=%0b want=0", cmd_ready); end
        for (int i = 0; i < 3; i++) begin
            pulse_done(16'h0010 + 16'(i), 3, 1'b0, rs);
            total++; if (rs !== ((i == 2) ? 1'b0 : 1'b1)) begin bad++; $display("FAIL step_done_run%0d got=%0b", i, rs); end
        end
        total++; if (halted !== 1'b1) begin bad++; $display("FAIL step_halted got=%0b want=1", halted); end
        total++; if (halt_cause !== 2'd2) begin bad++; $display("FAIL step_cause got=%0d want=2", halt_cause); end
        total++; if (instr_count !== 32'd3) begin bad++; $display("FAIL step_instr got=%0d want=3", instr_count); end
        total++; if (cycle_count !== 32'd11) begin bad++; $display("FAIL step_cycle got=%0d want=11", cycle_count); end
        total++; if (trace_count !== 4'd3) begin bad++; $display("FAIL step_tcount got=%0d want=3", trace_count); end
        for (int i = 0; i < 3; i++) begin
            total++; if (trace_pc !== 16'h0010 + 16'(i)) begin bad++; $display("FAIL step_trace%0d got=%h want=%h", i, trace_pc, 16'h0010 + 16'(i)); end
            trace_rd = 1'b1;
            @(negedge clk);
            trace_rd = 1'b0;
        end
        total++; if (trace_empty !== 1'b1) begin bad++; $display("FAIL step_trace_empty got=%0b want=1", trace_empty); end
    endtask

    task automatic test_breakpoint();
        logic rs;
        send_cmd(OP_CLR, 8'd0);
        write_bp(1'b0, 16'h0004, 1'b1);
        send_cmd(OP_RUN, 8'd0);
        for (int i = 1; i <= 3; i++) begin
            pulse_done(16'(i), 2, 1'b0, rs);
            total++; if (rs !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL bp_pre%0d run=%0b halted=%0b want 1/0", i, rs, halted); end
        end
        pulse_done(16'h0004, 2, 1'b0, rs);
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL bp_gate got=%0b want=0", rs); end
        total++; if (halted !== 1'b1 || halt_cause !== 2'd3) begin bad++; $display("FAIL bp_halt halted=%0b cause=%0d want 1/3", halted, halt_cause); end
        total++; if (instr_count !== 32'd4) begin bad++; $display("FAIL bp_instr got=%0d want=4", instr_count); end
        send_cmd(OP_RUN, 8'd0);
        total++; if (proc_run !== 1'b1) begin bad++; $display("FAIL bp_resume_run got=%0b want=1", proc_run); end
        pulse_done(16'h0005, 2, 1'b0, rs);
        total++; if (rs !== 1'b1 || halted !== 1'b0 || instr_count !== 32'd5) begin bad++; $display("FAIL bp_resume run=%0b halted=%0b instr=%0d want 1/0/5", rs, halted, instr_count); end
    endtask

    task automatic test_halt_cmd();
        logic rs;
        total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL halt_ready_run got=%0b want=1", cmd_ready); end
        send_cmd(OP_HALT, 8'd0);
        total++; if (cmd_ready !== 1'b0 || proc_run !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL halt_drain ready=%0b run=%0b halted=%0b want 0/1/0", cmd_ready, proc_run, halted); end
        repeat (2) @(negedge clk);
        total++; if (proc_run !== 1'b1) begin bad++; $display("FAIL halt_drain_hold got=%0b want=1", proc_run); end
        pulse_done(16'h0006, 1, 1'b0, rs);
        total++; if (rs !== 1'b0) begin bad++; $display("FAIL halt_gate got=%0b want=0", rs); end
        total++; if (halted !== 1'b1 || halt_cause !== 2'd1) begin bad++; $display("FAIL halt_state halted=%0b cause=%0d want 1/1", halted, halt_cause); end
        repeat (3) @(negedge clk);
        total++; if (proc_run !== 1'b0 || instr_count !== 32'd6) begin bad++; $display("FAIL halt_quiet run=%0b instr=%0d want 0/6", proc_run, instr_count); end
    endtask

    task automatic test_trace_wrap();
        logic rs;
        send_cmd(OP_CLR, 8'd0);
        send_cmd(OP_RUN, 8'd0);
        for (int i = 0; i < 9; i++) begin
            pulse_done(16'h0100 + 16'(i), 1, 1'b0, rs);
        end
        send_cmd(OP_HALT, 8'd0);
        pulse_done(16'h0109, 1, 1'b0, rs);
        total++; if (halted !== 1'b1 || instr_count !== 32'd10) begin bad++; $display("FAIL wrap_halt halted=%0b instr=%0d want 1/10", halted, instr_count); end
        total++; if (trace_count !== 4'd8 || trace_overflow !== 1'b1) begin bad++; $display("FAIL wrap_full count=%0d ovf=%0b want 8/1", trace_count, trace_overflow); end
        total++; if (trace_pc !== 16'h0102) begin bad++; $display("FAIL wrap_head got=%h want=0102", trace_pc); end
        trace_rd = 1'b1;
        @(negedge clk);
        trace_rd = 1'b0;
        total++; if (trace_pc !== 16'h0103 || trace_count !== 4'd7) begin bad++; $display("FAIL wrap_pop pc=%h count=%0d want 0103/7", trace_pc, trace_count); end
        send_cmd(OP_CLR, 8'd0);
        total++; if (trace_empty !== 1'b1 || trace_overflow !== 1'b0 || trace_count !== 4'd0) begin bad++; $display("FAIL clr_trace empty=%0b ovf=%0b count=%0d want 1/0/0", trace_empty, trace_overflow, trace_count); end
        total++; if (instr_count !== 32'd0 || cycle_count !== 32'd0 || halt_cause !== 2'd0) begin bad++; $display("FAIL clr_cnt instr=%0d cycle=%0d cause=%0d want 0/0/0", instr_count, cycle_count, halt_cause); end
        trace_rd = 1'b1;
        @(negedge clk);
        trace_rd = 1'b0;
        total++; if (trace_empty !== 1'b1 || trace_count !== 4'd0) begin bad++; $display("FAIL empty_pop empty=%0b count=%0d want 1/0", trace_empty, trace_count); end
        for (int i = 0; i < 8; i++) begin
            pulse_done(16'h0300 + 16'(i), 1, 1'b0, rs);
        end
        total++; if (trace_count !== 4'd8 || trace_overflow !== 1'b0 || proc_run !== 1'b0) begin bad++; $display("FAIL fill count=%0d ovf=%0b run=%0b want 8/0/0", trace_count, trace_overflow, proc_run); end
        pulse_done(16'h0308, 1, 1'b1, rs);
        total++; if (trace_count !== 4'd8 || trace_overflow !== 1'b0 || trace_pc !== 16'h0301) begin bad++; $display("FAIL pushpop count=%0d ovf=%0b pc=%h want 8/0/0301", trace_count, trace_overflow, trace_pc); end
        send_cmd(OP_CLR, 8'd0);
    endtask

    task automatic test_step_bp();
        logic rs;
        write_bp(1'b1, 16'h0202, 1'b1);
        send_cmd(OP_STEP, 8'd2);
        pulse_done(16'h0201, 2, 1'b0, rs);
        total++; if (rs !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL stepbp_first run=%0b halted=%0b want 1/0", rs, halted); end
        pulse_done(16'h0202, 2, 1'b0, rs);
        total++; if (rs !== 1'b0 || halted !== 1'b1 || halt_cause !== 2'd3) begin bad++; $display("FAIL stepbp_cause run=%0b halted=%0b cause=%0d want 0/1/3", rs, halted, halt_cause); end
        send_cmd(OP_STEP, 8'd0);
        total++; if (halted !== 1'b1 || proc_run !== 1'b0 || cmd_ready !== 1'b1) begin bad++; $display("FAIL step0 halted=%0b run=%0b ready=%0b want 1/0/1", halted, proc_run, cmd_ready); end
        repeat (2) @(negedge clk);
        total++; if (proc_run !== 1'b0 || halt_cause !== 2'd3) begin bad++; $display("FAIL step0_hold run=%0b cause=%0d want 0/3", proc_run, halt_cause); end
    endtask

    task automatic test_async_reset();
        logic rs;
        send_cmd(OP_RUN, 8'd0);
        pulse_done(16'h0400, 1, 1'b0, rs);
        total++; if (instr_count !== 32'd3 || proc_run !== 1'b1) begin bad++; $display("FAIL prereset instr=%0d run=%0b want 3/1", instr_count, proc_run); end
        #2 rst = 1'b1;
        #1;
        total++; if (proc_run !== 1'b0 || halted !== 1'b1) begin bad++; $display("FAIL async_run run=%0b halted=%0b want 0/1", proc_run, halted); end
        total++; if (instr_count !== 32'd0 || cycle_count !== 32'd0 || trace_empty !== 1'b1) begin bad++; $display("FAIL async_state instr=%0d cycle=%0d empty=%0b want 0/0/1", instr_count, cycle_count, trace_empty); end
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send_cmd(OP_RUN, 8'd0);
        pulse_done(16'h0004, 1, 1'b0, rs);
        total++; if (rs !== 1'b1 || halted !== 1'b0) begin bad++; $display("FAIL reset_bp_cleared run=%0b halted=%0b want 1/0", rs, halted); end
    endtask

    initial begin
        test_reset();
        test_step();
        test_breakpoint();
        test_halt_cmd();
        test_trace_wrap();
        test_step_bp();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
